uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 95 +++++++++
 tb/tb_uart_tx_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS payload LSB first,
// optional even/odd parity, one or two stop bits, valid/ready request port.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  state_t                state, state_next;
  logic [15:0]           baud_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  parity_bit;
  logic                  tx_next;
  logic                  accept;
  logic                  baud_done;

  assign accept    = tx_valid && tx_ready;
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = START;
      START: if (baud_done) state_next = DATA;
      DATA:  if (baud_done && bit_cnt == DATA_LAST)
               state_next = (PARITY != 0) ? PAR : STOP;
      PAR:   if (baud_done) state_next = STOP;
      STOP:  if (baud_done && bit_cnt == STOP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE) && !reset;
    busy     = (state != IDLE);
    tx_next  = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      PAR:     tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
  end

  // tx is a registered decode of the current state, so the line lags the
  // state by one cycle: the start bit appears one edge after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      tx <= tx_next;
      if (accept) begin
        shift_reg  <= tx_data;
        parity_bit <= (^tx_data) ^ (PARITY == 2);
        baud_cnt   <= '0;
        bit_cnt    <= '0;
      end else if (state != IDLE) begin
        if (baud_done) begin
          baud_cnt <= '0;
          if (state_next != state) bit_cnt <= '0;
          else                     bit_cnt <= bit_cnt + 4'd1;
          if (state == DATA) shift_reg <= shift_reg >> 1;
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets, table-driven frames
// plus hand-written back-to-back, mid-frame reset and reset-vs-accept sequences.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] ready;
  logic [3:0] tx_s;
  logic [3:0] busy_s;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N2; all at 4 clocks per bit
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .tx(tx_s[0]), .busy(busy_s[0]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .tx(tx_s[1]), .busy(busy_s[1]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .tx_valid(valid[2]), .tx_data(data[2]),
    .tx_ready(ready[2]), .tx(tx_s[2]), .busy(busy_s[2]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
    .tx_ready(ready[3]), .tx(tx_s[3]), .busy(busy_s[3]));

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] payload;
    logic [15:0] bits;   // bit i = i-th serial bit (start first)
    int         nbits;
    int         flen;    // busy cycles
    bit         poke;    // disturb tx_valid/tx_data mid-frame
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Sends one frame and checks the tx waveform cycle by cycle and busy length.
  task automatic applyStimulus(input vec_t v);
    int   bad_k;
    logic bad_act;
    logic exp_tx;
    int   busy_cnt;
    int   t;
    @(negedge clk);
    valid[v.dut] = 1'b1;
    data[v.dut]  = v.payload;
    t = 0;
    while (!ready[v.dut] && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput({v.name, "_ready"}, 32'(ready[v.dut]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid[v.dut] = 1'b0;
    data[v.dut]  = ~v.payload;
    bad_k    = -1;
    bad_act  = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k <= v.flen + 2; k++) begin
      if (busy_s[v.dut]) busy_cnt++;
      exp_tx = (k >= 1 && k <= 4 * v.nbits) ? v.bits[(k - 1) / 4] : 1'b1;
      if (tx_s[v.dut] !== exp_tx && bad_k < 0) begin
        bad_k   = k;
        bad_act = tx_s[v.dut];
      end
      if (v.poke && k == v.flen / 2) begin
        valid[v.dut] = 1'b1;
        data[v.dut]  = 8'h00;
      end
      if (v.poke && k == v.flen / 2 + 1) valid[v.dut] = 1'b0;
      @(negedge clk);
    end
    if (bad_k >= 0)
      $display("[TB] %s: first bad cycle %0d tx=%b", v.name, bad_k, bad_act);
    checkOutput({v.name, "_tx_first_bad_cycle"}, 32'(bad_k), 32'hFFFF_FFFF);
    checkOutput({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'(v.flen));
  endtask

  initial begin
    logic [15:0] f1;
    logic [15:0] f2;
    logic        exp_tx;
    int          bad_k;
    int          t;

    vecs[0] = '{"8n1_a5",   0, 8'hA5, 16'h034A, 10, 40, 1'b0};
    vecs[1] = '{"8n1_00",   0, 8'h00, 16'h0200, 10, 40, 1'b0};
    vecs[2] = '{"8n1_ff",   0, 8'hFF, 16'h03FE, 10, 40, 1'b0};
    vecs[3] = '{"8e1_07",   1, 8'h07, 16'h060E, 11, 44, 1'b0};
    vecs[4] = '{"8e1_01",   1, 8'h01, 16'h0602, 11, 44, 1'b0};
    vecs[5] = '{"8o1_07",   2, 8'h07, 16'h040E, 11, 44, 1'b0};
    vecs[6] = '{"8o1_00",   2, 8'h00, 16'h0600, 11, 44, 1'b0};
    vecs[7] = '{"7n2_7f",   3, 8'h7F, 16'h03FE, 10, 40, 1'b1};
    vecs[8] = '{"7n2_2a",   3, 8'h2A, 16'h0354, 10, 40, 1'b0};
    vecs[9] = '{"8n1_3c",   0, 8'h3C, 16'h0278, 10, 40, 1'b1};

    reset = 1'b1;
    valid = 4'b0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'h0);
    checkOutput("reset_tx", 32'(tx_s), 32'hF);
    checkOutput("reset_busy", 32'(busy_s), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(ready), 32'hF);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Back-to-back: valid held high, second start bit 41 cycles after the first
    f1 = 16'h02AA;
    f2 = 16'h0354;
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'h55;
    t = 0;
    while (!ready[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    data[0] = 8'hAA;
    bad_k = -1;
    for (int k = 0; k <= 85; k++) begin
      if (k >= 1 && k <= 40)       exp_tx = f1[(k - 1) / 4];
      else if (k >= 42 && k <= 81) exp_tx = f2[(k - 42) / 4];
      else                         exp_tx = 1'b1;
      if (tx_s[0] !== exp_tx && bad_k < 0) bad_k = k;
      if (k == 40) checkOutput("b2b_idle_busy", 32'(busy_s[0]), 32'd0);
      if (k == 41) begin
        checkOutput("b2b_idle_tx", 32'(tx_s[0]), 32'd1);
        checkOutput("b2b_second_busy", 32'(busy_s[0]), 32'd1);
        valid[0] = 1'b0;
      end
      if (k == 42) checkOutput("b2b_second_start", 32'(tx_s[0]), 32'd0);
      @(negedge clk);
    end
    checkOutput("b2b_tx_first_bad_cycle", 32'(bad_k), 32'hFFFF_FFFF);

    // Reset during data bit 3, then a fresh 0x3C frame
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("midrst_pre_busy", 32'(busy_s[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_tx", 32'(tx_s[0]), 32'd1);
    checkOutput("midrst_busy", 32'(busy_s[0]), 32'd0);
    checkOutput("midrst_ready_low", 32'(ready[0]), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_ready", 32'(ready[0]), 32'd1);
    applyStimulus(vecs[9]);

    // Reset wins over a simultaneous accept; the request is dropped
    @(negedge clk);
    valid[1] = 1'b1;
    data[1]  = 8'h07;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    reset    = 1'b0;
    checkOutput("rst_vs_accept_busy", 32'(busy_s[1]), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_vs_accept_busy_later", 32'(busy_s[1]), 32'd0);
    checkOutput("rst_vs_accept_tx", 32'(tx_s[1]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
